// File: rtl/serial_config_engine.sv
// Serial configuration engine: shifts a NUM_REGS x REG_W image into the TDC scan chain,
// optionally reads it back through p_sdo and flags mismatches; supports periodic auto-refresh.
module serial_config_engine #(
  parameter int unsigned NUM_REGS     = 13,
  parameter int unsigned REG_W        = 8,
  parameter int unsigned CLKDIV       = 4,
  parameter int unsigned RESET_CYCLES = 16,
  parameter bit          VERIFY       = 1'b1,
  parameter bit          INVERT_OUT   = 1'b1
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic [NUM_REGS*REG_W-1:0] cfg_bus,
  input  logic                      start,
  input  logic                      refresh_tick,
  input  logic                      auto_refresh_en,
  input  logic                      p_sdo,
  output logic                      p_reset,
  output logic                      p_sck,
  output logic                      p_sda,
  output logic                      p_scapt,
  output logic                      busy,
  output logic                      done,
  output logic                      mismatch,
  output logic [15:0]               err_count
);

  localparam int unsigned TOTAL = NUM_REGS * REG_W;
  localparam int unsigned BitW  = $clog2(TOTAL + 1);
  localparam int unsigned IdxW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned DivW  = $clog2(2 * CLKDIV);
  localparam int unsigned RstW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [BitW-1:0] BitLast = BitW'(TOTAL - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(2 * CLKDIV - 1);
  localparam logic [DivW-1:0] DivHigh = DivW'(CLKDIV);
  localparam logic [DivW-1:0] DivRise = DivW'(CLKDIV - 1);
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRstp, StShift, StCapt, StVrfy, StDone} state_e;

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [RstW-1:0]   rcnt_q, rcnt_d;
  logic [TOTAL-1:0]  image_q;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              trig, in_shift_d, sample;

  assign trig = start | (refresh_tick & auto_refresh_en);

  // Bits go out MSB first: bit counter n addresses image bit TOTAL-1-n.
  assign idx_q      = IdxW'(BitLast - bit_q);
  assign idx_d      = IdxW'(BitLast - bit_d);
  assign in_shift_d = (state_d == StShift) || (state_d == StVrfy);
  // p_sdo is taken on the clkin edge that raises sck, before the chip shifts.
  assign sample     = (state_q == StVrfy) && (div_q == DivRise);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = div_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StRstp;
          rcnt_d  = '0;
        end
      end
      StRstp: begin
        if (rcnt_q == RstLast) begin
          state_d = StShift;
          bit_d   = '0;
          div_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RstW'(1);
        end
      end
      StShift, StVrfy: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == BitLast) begin
            state_d = (state_q == StShift) ? StCapt : StDone;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StCapt: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = VERIFY ? StVrfy : StDone;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_q     <= '0;
      div_q     <= '0;
      rcnt_q    <= '0;
      image_q   <= '0;
      p_reset   <= INVERT_OUT;
      p_sck     <= INVERT_OUT;
      p_sda     <= INVERT_OUT;
      p_scapt   <= INVERT_OUT;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      rcnt_q  <= rcnt_d;
      if (state_q == StIdle && trig) begin
        image_q  <= cfg_bus;
        mismatch <= 1'b0;
      end else if (sample && (p_sdo != image_q[idx_q])) begin
        mismatch <= 1'b1;
      end
      if (state_d == StDone && mismatch && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      p_reset <= (state_d == StRstp) ^ INVERT_OUT;
      p_sck   <= (in_shift_d && (div_d >= DivHigh)) ^ INVERT_OUT;
      p_sda   <= (in_shift_d && image_q[idx_d]) ^ INVERT_OUT;
      p_scapt <= (state_d == StCapt) ^ INVERT_OUT;
      busy    <= (state_d != StIdle) && (state_d != StDone);
      done    <= (state_d == StDone);
    end
  end

endmodule
